// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes (also used by the decoder),
// ALU sequencer FSM states and width-derived constants.
package cpu_pkg;

  // Native datapath width of the CPU.
  localparam int CPU_WIDTH  = 8;
  // Full multiply product width.
  localparam int PROD_WIDTH = 2 * CPU_WIDTH;
  // Iteration counter must be able to hold the value CPU_WIDTH itself.
  localparam int CNT_WIDTH  = $clog2(CPU_WIDTH) + 1;

  // ALU opcodes.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // ALU sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10,
    DONE = 2'b11
  } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier datapath. The iteration counter lives in the
// caller; this block only loads operands and performs one step per
// asserted i_step.
module alu_mul_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_product
);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;

  // Load clears the accumulator; each step conditionally adds the shifted
  // multiplicand, then advances multiplicand left and multiplier right.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (i_step) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
    end
  end

  assign o_product = r_acc;

endmodule

// File: rtl/alu_sequencer.sv
// Registered ALU stage: accepts an op on start/ready, computes either a
// single-cycle logic/arithmetic result or an iterative multiply, and
// presents alu_out/carry/zero with a one-cycle save strobe.
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             save,
  output logic             carry,
  output logic             zero
);

  localparam int             CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  MUL_LAST = CW'(WIDTH);

  alu_state_t       r_state;
  logic [2:0]       r_opcode;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_stage_res;
  logic             r_stage_c;
  logic [WIDTH-1:0] r_alu_out;
  logic             r_carry;
  logic             r_zero;

  logic             w_accept;
  logic             w_mul_step;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic [2*WIDTH-1:0] w_product;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_mul_step = (r_state == MUL) && (r_cnt != MUL_LAST);
  assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff     = {1'b0, r_a} - {1'b0, r_b};

  // Single-cycle ALU operations on the latched operands.
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    case (r_opcode)
      OP_ADD: {w_alu_c, w_alu_res} = w_sum;
      OP_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_c   = w_diff[WIDTH];   // borrow out of the top bit
      end
      OP_AND: w_alu_res = r_a & r_b;
      OP_OR:  w_alu_res = r_a | r_b;
      OP_XOR: w_alu_res = r_a ^ r_b;
      OP_SHL: begin
        w_alu_res = {r_a[WIDTH-2:0], 1'b0};
        w_alu_c   = r_a[WIDTH-1];
      end
      OP_SHR: begin
        w_alu_res = {1'b0, r_a[WIDTH-1:1]};
        w_alu_c   = r_a[0];
      end
      default: begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
      end
    endcase
  end

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_accept),
    .i_step    (w_mul_step),
    .i_a       (operand_a),
    .i_b       (operand_b),
    .o_product (w_product)
  );

  // Sequencer FSM: latch on accept, stage the ALU result (or iterate the
  // multiplier), commit outputs on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_opcode    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_stage_res <= '0;
      r_stage_c   <= 1'b0;
      r_alu_out   <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_opcode <= opcode;
            r_a      <= operand_a;
            r_b      <= operand_b;
            r_cnt    <= '0;
            r_state  <= (opcode == OP_MUL) ? MUL : EXEC;
          end
        end
        EXEC: begin
          // First cycle registers the combinational result, second commits
          // it, so the output path never sees the raw ALU logic.
          if (r_cnt == '0) begin
            r_stage_res <= w_alu_res;
            r_stage_c   <= w_alu_c;
            r_cnt       <= CNT_ONE;
          end else begin
            r_alu_out <= r_stage_res;
            r_carry   <= r_stage_c;
            r_zero    <= (r_stage_res == '0);
            r_state   <= DONE;
          end
        end
        MUL: begin
          if (r_cnt == MUL_LAST) begin
            r_alu_out <= w_product[WIDTH-1:0];
            r_carry   <= |w_product[2*WIDTH-1:WIDTH];
            r_zero    <= (w_product[WIDTH-1:0] == '0);
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready   = (r_state == IDLE);
  assign save    = (r_state == DONE);
  assign alu_out = r_alu_out;
  assign carry   = r_carry;
  assign zero    = r_zero;

endmodule
